frame_pipeline_ctrl: RTL



---
 rtl/frame_pipeline_pkg.sv | 23 ++
 rtl/frame_pipeline_ctrl_sync_edge.sv | 32 +++
 rtl/frame_pipeline_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/frame_pipeline_pkg.sv
// Shared state encodings and mode constants for the frame capture / recognition sequencer.
package frame_pipeline_pkg;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_ARM     = 2'd1,
    C_CAPTURE = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_RECOG  = 2'd1,
    P_SEND   = 2'd2,
    P_TXWAIT = 2'd3
  } proc_state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

  // Minimum cycles spent in P_TXWAIT after the Tx start pulse before busy is trusted.
  localparam logic [1:0] TXWAIT_MIN = 2'd2;

endpackage

// File: rtl/frame_pipeline_ctrl_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by an edge-detect flop
// that yields one-cycle rise and fall pulses in the clk domain.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/frame_pipeline_ctrl.sv
// Capture / recognition / Tx sequencer with optional double buffering and status counters.
// Define FRAME_PIPELINE_TIMEOUT_EN to build the per-stage watchdog driving o_Error.
module frame_pipeline_ctrl
  import frame_pipeline_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int FRAME_BYTES = 11376,
  parameter int DATA_W      = 8,
  parameter int NUM_BANKS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              i_Rst,
  input  logic              i_VS,
  input  logic              i_Frame_Indicator,
  input  logic              i_Mode,
  output logic              o_Capture_En,
  output logic [ADDR_W-1:0] o_Write_Base,
  output logic              o_Recog_Start,
  output logic [ADDR_W-1:0] o_Read_Base,
  input  logic              i_Recog_Done,
  input  logic [DATA_W-1:0] i_Result,
  output logic              o_Tx_Start,
  output logic [DATA_W-1:0] o_Tx_Data,
  input  logic              i_Tx_Busy,
  output logic [CNT_W-1:0]  o_Frames,
  output logic [CNT_W-1:0]  o_Dropped,
  output logic              o_Error
);

  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_BYTES);

  cap_state_t  cap_state_reg;
  proc_state_t proc_state_reg;
  logic        armed_reg;
  logic        mode_reg;
  logic [1:0]  txw_cnt_reg;

  logic vs_rise, vs_fall, trig_rise, trig_fall_unused;
  logic bank_free, frame_done, handoff, frame_drop, tx_exit;
  logic stage_timeout, timeout_fire;
  logic [CNT_W:0] dropped_sum;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vs_sync (
    .clk  (Clk),
    .rst  (i_Rst),
    .din  (i_VS),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
    .clk  (Clk),
    .rst  (i_Rst),
    .din  (i_Frame_Indicator),
    .rise (trig_rise),
    .fall (trig_fall_unused)
  );

  // A single bank can only be re-armed once recognition has released it.
  assign bank_free  = (NUM_BANKS == 2) ? 1'b1 : (proc_state_reg == P_IDLE);
  assign frame_done = (cap_state_reg == C_CAPTURE) && vs_rise;
  assign handoff    = frame_done && (proc_state_reg == P_IDLE);
  assign frame_drop = frame_done && (proc_state_reg != P_IDLE);
  assign tx_exit    = (txw_cnt_reg == TXWAIT_MIN) && !i_Tx_Busy;

  assign timeout_fire = stage_timeout &&
                        (((proc_state_reg == P_RECOG) && !i_Recog_Done) ||
                         ((proc_state_reg == P_TXWAIT) && !tx_exit));

  assign dropped_sum = {1'b0, o_Dropped} + (CNT_W+1)'(frame_drop) + (CNT_W+1)'(timeout_fire);

`ifdef FRAME_PIPELINE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_reg;

  assign stage_timeout = (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

  // Counter is held at zero outside the two waiting stages, so each stage starts fresh.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      wd_cnt_reg <= '0;
      o_Error    <= 1'b0;
    end else begin
      if (proc_state_reg == P_IDLE || proc_state_reg == P_SEND) begin
        wd_cnt_reg <= '0;
      end else if (!stage_timeout) begin
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      end
      if (timeout_fire) begin
        o_Error <= 1'b1;
      end
    end
  end
`else
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign stage_timeout = 1'b0;
  assign o_Error       = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      cap_state_reg <= C_IDLE;
      armed_reg     <= 1'b0;
      mode_reg      <= MODE_SINGLE;
      o_Capture_En  <= 1'b0;
    end else begin
      if (cap_state_reg == C_IDLE) begin
        mode_reg <= i_Mode;
      end
      if (mode_reg == MODE_CONT || trig_rise) begin
        armed_reg <= 1'b1;
      end else if (cap_state_reg == C_ARM && vs_fall) begin
        armed_reg <= 1'b0;
      end
      case (cap_state_reg)
        C_IDLE: begin
          if (armed_reg && bank_free) cap_state_reg <= C_ARM;
        end
        C_ARM: begin
          if (vs_fall) begin
            cap_state_reg <= C_CAPTURE;
            o_Capture_En  <= 1'b1;
          end
        end
        C_CAPTURE: begin
          if (vs_rise) begin
            cap_state_reg <= C_IDLE;
            o_Capture_En  <= 1'b0;
          end
        end
        default: begin
          cap_state_reg <= C_IDLE;
          o_Capture_En  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      proc_state_reg <= P_IDLE;
      txw_cnt_reg    <= '0;
      o_Recog_Start  <= 1'b0;
      o_Tx_Start     <= 1'b0;
      o_Read_Base    <= '0;
      o_Write_Base   <= '0;
      o_Tx_Data      <= '0;
      o_Frames       <= '0;
      o_Dropped      <= '0;
    end else begin
      o_Recog_Start <= 1'b0;
      o_Tx_Start    <= 1'b0;
      o_Dropped     <= dropped_sum[CNT_W] ? '1 : dropped_sum[CNT_W-1:0];
      // A dropped frame leaves the write base alone so the same bank is overwritten.
      if (handoff) begin
        o_Read_Base   <= o_Write_Base;
        o_Recog_Start <= 1'b1;
        if (NUM_BANKS == 2) begin
          o_Write_Base <= (o_Write_Base == BANK1_BASE) ? '0 : BANK1_BASE;
        end
      end
      case (proc_state_reg)
        P_IDLE: begin
          if (handoff) proc_state_reg <= P_RECOG;
        end
        P_RECOG: begin
          if (i_Recog_Done) begin
            o_Tx_Data      <= i_Result;
            proc_state_reg <= P_SEND;
          end else if (timeout_fire) begin
            proc_state_reg <= P_IDLE;
          end
        end
        P_SEND: begin
          if (!i_Tx_Busy) begin
            o_Tx_Start     <= 1'b1;
            txw_cnt_reg    <= '0;
            proc_state_reg <= P_TXWAIT;
          end
        end
        P_TXWAIT: begin
          if (txw_cnt_reg != TXWAIT_MIN) txw_cnt_reg <= txw_cnt_reg + 2'd1;
          if (tx_exit) begin
            if (o_Frames != '1) o_Frames <= o_Frames + CNT_W'(1);
            proc_state_reg <= P_IDLE;
          end else if (timeout_fire) begin
            proc_state_reg <= P_IDLE;
          end
        end
        default: proc_state_reg <= P_IDLE;
      endcase
    end
  end

endmodule
